// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Purpose  : Shared defaults and loader state encoding for the FFT frame path.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int DEF_BIT_WIDTH      = 16;
  localparam int DEF_N              = 9;
  localparam int DEF_FFT_SIZE       = 1 << DEF_N;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_loader
// Purpose  : Packs audio samples into natural-order FFT frames and sequences
//            the load / start / done handshake with the FFT core.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH      = DEF_BIT_WIDTH,
  parameter int N              = DEF_N,
  parameter int FFT_SIZE       = DEF_FFT_SIZE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic signed [BIT_WIDTH-1:0] sample,
  input  logic                        fft_done,
  output logic                        fft_load,
  output logic        [N-1:0]         add_rd,
  output logic signed [BIT_WIDTH-1:0] din,
  output logic                        fft_start,
  output logic                        busy,
  output logic        [15:0]          frame_count,
  output logic        [7:0]           drop_count,
  output logic                        timeout_err
);

  localparam int                 WAIT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [N-1:0]       C_LAST_INDEX = N'(FFT_SIZE - 1);
  localparam logic [WAIT_W-1:0]  C_WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);

  loader_state_t     r_state;
  logic [N-1:0]      r_index;
  logic [WAIT_W-1:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_wait_cnt  <= '0;
      fft_load    <= 1'b0;
      add_rd      <= '0;
      din         <= '0;
      fft_start   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      fft_load  <= 1'b0;
      fft_start <= 1'b0;

      // Samples arriving while the core owns the frame are lost; count them.
      if ((r_state == ST_START || r_state == ST_WAIT) && sample_valid &&
          drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end

      case (r_state)
        ST_IDLE: begin
          busy    <= 1'b0;
          r_index <= '0;
          if (enable) begin
            r_state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_index <= '0;
          end else if (sample_valid) begin
            fft_load <= 1'b1;
            add_rd   <= r_index;
            din      <= sample;
            r_index  <= r_index + 1'b1;
            if (r_index == C_LAST_INDEX) begin
              r_state <= ST_START;
              busy    <= 1'b1;
            end
          end
        end

        // First START cycle carries the final fft_load; the pulse follows it.
        ST_START: begin
          if (!fft_start) begin
            fft_start <= 1'b1;
          end else begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= '0;
          end
        end

        ST_WAIT: begin
          if (fft_done || r_wait_cnt == C_WAIT_LAST) begin
            if (fft_done) begin
              frame_count <= frame_count + 16'd1;
            end else begin
              timeout_err <= 1'b1;
            end
            r_wait_cnt <= '0;
            r_index    <= '0;
            busy       <= 1'b0;
            r_state    <= enable ? ST_LOAD : ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
